// File: rtl/warmboot_pkg.sv
// warmboot_pkg: shared types for the warm-boot sequencer.
package warmboot_pkg;
  localparam int IMG_W = 2;
  typedef logic [IMG_W-1:0] img_t;
  typedef enum logic [1:0] {IDLE, SETUP, ARMED, DONE} state_t;
endpackage

// File: rtl/warmboot_ctrl_debounce.sv
// debounce: 2-flop synchronizer, saturating stability counter and rising-edge pulse.
module debounce #(
  parameter int LOG2 = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic level,
  output logic rise
);
  logic [1:0] sync;
  logic [LOG2-1:0] cnt;
  logic diff, sat;
  assign diff = sync[1] ^ level;
  assign sat = &cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], in_raw};
      cnt <= diff && !sat ? cnt + 1'b1 : '0;
      level <= level ^ (diff && sat);
      rise <= diff && sat && !level;
    end
  end
endmodule

// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl: sequences image select then BOOT for the SB_WARMBOOT primitive.
module warmboot_ctrl
  import warmboot_pkg::*;
#(
  parameter int   DEBOUNCE_LOG2 = 16,
  parameter int   SETUP_CYCLES  = 16,
  parameter img_t DEFAULT_IMAGE = 2'd0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_next,
  input  logic btn_boot,
  input  logic req,
  input  img_t req_image,
  output logic busy,
  output img_t image,
  output logic wb_boot,
  output logic wb_s1,
  output logic wb_s0
);
  state_t state, state_n;
  img_t image_n;
  logic [7:0] cnt;
  logic ev_next, ev_boot, lvl_next, lvl_boot, idle, go;
  debounce #(.LOG2(DEBOUNCE_LOG2)) u_next (
    .clk(clk), .rst(rst), .in_raw(btn_next), .level(lvl_next), .rise(ev_next)
  );
  debounce #(.LOG2(DEBOUNCE_LOG2)) u_boot (
    .clk(clk), .rst(rst), .in_raw(btn_boot), .level(lvl_boot), .rise(ev_boot)
  );
  assign idle = state == IDLE;
  assign go = idle && (req || ev_boot);
  assign busy = !idle;
  assign {wb_s1, wb_s0} = image;
  always_comb begin
    image_n = !idle ? image : req ? req_image : (!ev_boot && ev_next) ? image + 1'b1 : image;
    state_n = go ? SETUP
            : state == SETUP ? (cnt == 8'd0 ? ARMED : SETUP)
            : state == ARMED ? DONE
            : state;
  end
  // wb_boot registered from the next state so it rises exactly as ARMED is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      image <= DEFAULT_IMAGE;
      cnt <= '0;
      wb_boot <= 1'b0;
    end else begin
      state <= state_n;
      image <= image_n;
      cnt <= go ? 8'(SETUP_CYCLES - 1) : state == SETUP ? cnt - 8'd1 : cnt;
      wb_boot <= state_n == ARMED || state_n == DONE;
    end
  end
endmodule

// File: tb/tb_warmboot_ctrl.sv
// tb_warmboot_ctrl: directed plan plus random stimulus against a cycle-level behavioural model.
module tb_warmboot_ctrl;
  import warmboot_pkg::*;
  localparam int SC = 4;
  localparam int STABLE = 4;
  logic clk = 0, rst = 1, btn_next = 0, btn_boot = 0, req = 0;
  img_t req_image = '0;
  logic busy, wb_boot, wb_s1, wb_s0;
  img_t image;
  int errs = 0, checks = 0;
  typedef struct {bit r1; bit r2; bit lvl; bit ev; int run;} db_t;
  db_t mn, mb;
  bit m_busy;
  int m_age, m_img;
  warmboot_ctrl #(.DEBOUNCE_LOG2(2), .SETUP_CYCLES(SC), .DEFAULT_IMAGE(2'd0)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_boot(btn_boot), .req(req),
    .req_image(req_image), .busy(busy), .image(image), .wb_boot(wb_boot),
    .wb_s1(wb_s1), .wb_s0(wb_s0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    mn = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};
    m_busy = 0;
    m_age = 0;
    m_img = 0;
  endtask
  // a button level flips once the synchronized input has disagreed with it for STABLE edges
  function automatic void db_step(inout db_t d, input bit raw);
    bit s;
    s = d.r2;
    d.r2 = d.r1;
    d.r1 = raw;
    d.ev = 0;
    if (s != d.lvl) begin
      d.run++;
      if (d.run == STABLE) begin
        d.lvl = !d.lvl;
        d.run = 0;
        d.ev = d.lvl;
      end
    end else d.run = 0;
  endfunction
  task automatic model_edge();
    if (rst) model_reset();
    else begin
      if (!m_busy) begin
        if (req) begin
          m_img = int'(req_image);
          m_busy = 1;
          m_age = 0;
        end else if (mb.ev) begin
          m_busy = 1;
          m_age = 0;
        end else if (mn.ev) m_img = (m_img + 1) % 4;
      end
      if (m_busy && m_age < 1000) m_age++;
      db_step(mn, btn_next);
      db_step(mb, btn_boot);
    end
  endtask
  task automatic check_all();
    chk("image", int'(image), m_img);
    chk("busy", int'(busy), int'(m_busy));
    chk("wb_boot", int'(wb_boot), int'(m_busy && m_age > SC));
    chk("s1s0", int'({wb_s1, wb_s0}), m_img);
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    check_all();
    step();
    rst = 0;
  endtask
  task automatic press(input bit boot_btn);
    if (boot_btn) btn_boot = 1; else btn_next = 1;
    repeat (10) step();
    btn_boot = 0;
    btn_next = 0;
    repeat (10) step();
  endtask
  initial begin
    bit hit;
    model_reset();
    repeat (2) step();
    rst = 0;
    repeat (100) step();
    chk("t1_idle", int'({busy, wb_boot, image}), 0);
    req = 1;
    req_image = 2;
    step();
    req = 0;
    chk("t2_busy", int'(busy), 1);
    chk("t2_s1s0", int'({wb_s1, wb_s0}), 2);
    step();
    req = 1;
    req_image = 3;
    step();
    req = 0;
    step();
    chk("t2_boot_low", int'(wb_boot), 0);
    step();
    chk("t2_boot_high", int'(wb_boot), 1);
    repeat (5) step();
    chk("t2_image_held", int'(image), 2);
    chk("t2_done", int'({busy, wb_boot}), 3);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press(0);
      chk("t3_step", int'(image), (i + 1) % 4);
    end
    press(1);
    chk("t3_boot", int'({busy, wb_boot, image}), 13);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      btn_next = ~btn_next;
      repeat (2) step();
    end
    btn_next = 0;
    repeat (10) step();
    chk("t4_bounce", int'({busy, image}), 0);
    btn_next = 1;
    btn_boot = 1;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      hit = mn.ev && mb.ev;
    end
    chk("t5_events", int'(hit), 1);
    req = 1;
    req_image = 3;
    step();
    req = 0;
    btn_next = 0;
    btn_boot = 0;
    chk("t5_image", int'({busy, image}), 7);
    repeat (10) step();
    chk("t5_boot", int'({wb_boot, image}), 7);
    do_reset();
    req = 1;
    req_image = 1;
    step();
    req = 0;
    step();
    do_reset();
    chk("t6_setup_rst", int'({busy, wb_boot, image}), 0);
    req = 1;
    step();
    req = 0;
    repeat (10) step();
    do_reset();
    chk("t6_done_rst", int'({busy, wb_boot, image}), 0);
    req = 1;
    req_image = 2;
    step();
    req = 0;
    repeat (6) step();
    chk("t6_fresh", int'({busy, wb_boot, image}), 14);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_next = ~btn_next;
      if ($urandom_range(0, 7) == 0) btn_boot = ~btn_boot;
      req = $urandom_range(0, 19) == 0;
      req_image = img_t'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) do_reset();
      else step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
